// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor.
//   ST_*       : FSM state encodings (IDLE / RUN / DONE)
//   DEF_WIDTH  : default operand width
package sub_pkg;
    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/fs_bit.sv
// 1-bit full subtractor cell: d = x - y - z, bo = borrow out.
//   x  : minuend bit
//   y  : subtrahend bit
//   z  : borrow in
//   d  : difference bit
//   bo : borrow out
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic z,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ z;
    assign bo = (~x & y) | (~(x ^ y) & z);
endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one fs_bit cell walked LSB-first over WIDTH cycles
// to produce diff = a - b - bin, with a start/done handshake.
//   clk, rst_n : clock, async active-low reset
//   start      : request, accepted in IDLE or DONE
//   a, b, bin  : operands, captured on an accepted start
//   busy       : high while the cell is being sequenced
//   done       : one-cycle pulse when diff/bout are updated
//   diff, bout : result and final borrow, held until the next completion
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d, bo;
    logic             last;

    fs_bit u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .z  (br),
        .d  (d),
        .bo (bo)
    );

    assign last = (cnt == CW'(WIDTH - 1));
    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE so ops can
                // run back-to-back without a bubble.
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        br    <= bin;
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= bo;
                    cnt    <= cnt + 1'b1;
                    // Commit from the cell output directly so the final bit
                    // lands in diff on the same edge; diff never shows partials.
                    if (last) begin
                        diff  <= {d, res_sr[WIDTH-1:1]};
                        bout  <= bo;
                        state <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub_ctrl.sv
module tb_serial_sub_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, bin8 = 1'b0, busy8, done8, bout8;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       start2 = 1'b0, bin2 = 1'b0, busy2, done2, bout2;
    logic [1:0] a2 = '0, b2 = '0, diff2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_sub_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, reduced mod 2^w.
    task automatic op(input bit sel2, input int av, input int bv, input int bi, input string tag);
        int w, r, lat, bcnt, exp_d, exp_b;
        bit seen;
        w     = sel2 ? 2 : 8;
        r     = av - bv - bi;
        exp_b = (r < 0) ? 1 : 0;
        exp_d = r & ((1 << w) - 1);
        @(negedge clk);
        if (sel2) begin a2 = 2'(av); b2 = 2'(bv); bin2 = 1'(bi); start2 = 1'b1; end
        else      begin a8 = 8'(av); b8 = 8'(bv); bin8 = 1'(bi); start8 = 1'b1; end
        @(posedge clk); #1;
        start2 = 1'b0; start8 = 1'b0;
        bcnt = (sel2 ? busy2 : busy8) ? 1 : 0;
        lat  = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (sel2 ? done2 : done8) begin seen = 1; break; end
            if (sel2 ? busy2 : busy8) bcnt++;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(w));
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'(w));
        chk({tag, "_busy_in_done"}, 32'(sel2 ? busy2 : busy8), 32'd0);
        chk({tag, "_diff"}, 32'(sel2 ? diff2 : diff8), 32'(exp_d));
        chk({tag, "_bout"}, 32'(sel2 ? bout2 : bout8), 32'(exp_b));
    endtask

    initial begin
        int pulses;
        bit seen;
        #12;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        op(0, 100, 37, 0, "d100_37");
        op(0, 5, 9, 0, "d5_9");
        op(0, 0, 0, 1, "d0_0_1");
        op(0, 255, 255, 1, "dff_ff_1");

        // A start during RUN must be ignored
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd2; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8) begin seen = 1; break; end
        end
        chk("ign_done_seen", 32'(seen), 32'd1);
        chk("ign_diff", 32'(diff8), 32'd30);
        chk("ign_bout", 32'(bout8), 32'd0);
        // Back-to-back: start driven during the done cycle
        op(0, 7, 3, 0, "b2b");

        // Reset mid-RUN
        op(0, 200, 1, 0, "pre_rst");
        @(negedge clk);
        a8 = 8'd60; b8 = 8'd10; start8 = 1'b1;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy8), 32'd0);
        chk("mid_rst_done", 32'(done8), 32'd0);
        chk("mid_rst_diff", 32'(diff8), 32'd0);
        chk("mid_rst_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) pulses++;
        end
        chk("post_rst_quiet", 32'(pulses), 32'd0);
        op(0, 9, 4, 0, "post_rst_op");

        // Randomized 8-bit ops
        for (int i = 0; i < 20; i++)
            op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)), "rnd8");

        // WIDTH=2 exhaustive
        for (int x = 0; x < 4; x++)
            for (int y = 0; y < 4; y++)
                for (int z = 0; z < 2; z++)
                    op(1, x, y, z, "ex2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Standing invariant: done and busy never overlap.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done8 && busy8) chk("overlap8", 32'd1, 32'd0);
            if (done2 && busy2) chk("overlap2", 32'd1, 32'd0);
        end
    end
endmodule
